// File: rtl/rst_seq_pkg.sv
// ============================================================================
// rst_seq_pkg: shared types and constants for the reset sequencer  (rev 1.0)
// ============================================================================
`default_nettype none

package rst_seq_pkg;

  localparam int CAUSE_W    = 4;
  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_PLL  = 1;
  localparam int CAUSE_BTN  = 2;
  localparam int CAUSE_SOFT = 3;

  // Upper bound on domain count; mask arithmetic is done on this width.
  localparam int MAX_RST = 32;

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_SOFT      = 3'd4
  } rst_state_e;

  // Number of set mask bits strictly below position idx.
  function automatic int mask_rank(input logic [MAX_RST-1:0] mask, input int idx);
    int n;
    n = 0;
    for (int j = 0; j < MAX_RST; j++) begin
      if ((j < idx) && mask[j]) n++;
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rst_seq_debounce.sv
// ============================================================================
// rst_debounce: 2-flop synchroniser plus stability-count debouncer  (rev 1.0)
// ============================================================================
`default_nettype none

module rst_debounce #(
  parameter int DEBOUNCE = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  generate
    if (DEBOUNCE < 1) begin : g_chk_debounce
      $error("rst_debounce: DEBOUNCE must be at least 1");
    end
  endgenerate

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // A sample equal to the current level restarts the count; DEBOUNCE
  // consecutive differing samples flip the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rst_seq.sv
// ============================================================================
// rst_seq: staggered multi-domain reset sequencer with reset cause  (rev 1.0)
// ============================================================================
`default_nettype none

module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int                 NUM_RST    = 2,
  parameter int                 CTR_W      = 8,
  parameter int                 MIN_ASSERT = 16,
  parameter int                 STEP       = 10,
  parameter int                 DEBOUNCE   = 1024,
  parameter logic [NUM_RST-1:0] SOFT_MASK  = 'b10
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               PLL_LOCKED,
  input  logic               BTN,
  input  logic               SYSRESETREQ,
  input  logic               CAUSE_CLR,
  output logic [NUM_RST-1:0] RSTn,
  output logic               READY,
  output logic [CAUSE_W-1:0] RST_CAUSE
);

  localparam int HARD_SPAN = (NUM_RST - 1) * STEP;
  localparam int CTR_NEED  = (MIN_ASSERT > HARD_SPAN) ? MIN_ASSERT : HARD_SPAN;
  localparam int SOFT_CNT  = mask_rank(MAX_RST'(SOFT_MASK), NUM_RST);
  localparam int SOFT_SPAN = ((SOFT_CNT > 0) ? (SOFT_CNT - 1) : 0) * STEP;

  localparam logic [CTR_W-1:0]   ASSERT_LAST = CTR_W'(MIN_ASSERT - 1);
  localparam logic [CTR_W-1:0]   HARD_LAST   = CTR_W'(HARD_SPAN);
  localparam logic [CTR_W-1:0]   SOFT_LAST   = CTR_W'(SOFT_SPAN);
  localparam logic [CAUSE_W-1:0] CAUSE_RESET = CAUSE_W'(1 << CAUSE_POR);

  generate
    if (MIN_ASSERT < 2) begin : g_chk_min_assert
      $error("rst_seq: MIN_ASSERT must be at least 2");
    end
    if ((CTR_NEED >> CTR_W) != 0) begin : g_chk_ctr_w
      $error("rst_seq: CTR_W too narrow for MIN_ASSERT / STEP span");
    end
    if ((NUM_RST < 1) || (NUM_RST > MAX_RST)) begin : g_chk_num_rst
      $error("rst_seq: NUM_RST out of range");
    end
  endgenerate

  // Release thresholds: a hard sequence staggers every domain by index, a
  // soft one staggers only the masked domains by their rank in the mask.
  logic [CTR_W-1:0] hard_thr [NUM_RST];
  logic [CTR_W-1:0] soft_thr [NUM_RST];

  generate
    for (genvar gi = 0; gi < NUM_RST; gi++) begin : g_thr
      assign hard_thr[gi] = CTR_W'(gi * STEP);
      assign soft_thr[gi] = CTR_W'(mask_rank(MAX_RST'(SOFT_MASK), gi) * STEP);
    end
  endgenerate

  rst_state_e         state_q;
  rst_state_e         state_d;
  logic [CTR_W-1:0]   ctr_q;
  logic [CTR_W-1:0]   ctr_d;
  logic               soft_seq_q;
  logic               soft_seq_d;
  logic [NUM_RST-1:0] rstn_d;
  logic [CAUSE_W-1:0] cause_d;
  logic               lock_s1;
  logic               lock_s2;
  logic               lock_prev;
  logic               pll_loss;
  logic               btn_level;
  logic               btn_rise;

  rst_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_btn_debounce (
    .clk   (CLK),
    .rst   (RESET),
    .din   (BTN),
    .level (btn_level),
    .rise  (btn_rise)
  );

  assign pll_loss = lock_prev & ~lock_s2;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_ASSERT;
      ctr_q      <= '0;
      soft_seq_q <= 1'b0;
      RSTn       <= '0;
      RST_CAUSE  <= CAUSE_RESET;
      lock_s1    <= 1'b0;
      lock_s2    <= 1'b0;
      lock_prev  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      soft_seq_q <= soft_seq_d;
      RSTn       <= rstn_d;
      RST_CAUSE  <= cause_d;
      lock_s1    <= PLL_LOCKED;
      lock_s2    <= lock_s1;
      lock_prev  <= lock_s2;
    end
  end

  // Next state, counter and cause; PLL loss outranks the button, and both
  // outrank the soft request. A same-cycle event survives CAUSE_CLR.
  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    soft_seq_d = soft_seq_q;
    cause_d    = CAUSE_CLR ? '0 : RST_CAUSE;
    if (pll_loss) begin
      state_d            = ST_ASSERT;
      ctr_d              = '0;
      cause_d[CAUSE_PLL] = 1'b1;
    end else if (btn_rise) begin
      state_d            = ST_ASSERT;
      ctr_d              = '0;
      cause_d[CAUSE_BTN] = 1'b1;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (btn_level) begin
            ctr_d = '0;
          end else if (ctr_q == ASSERT_LAST) begin
            state_d = ST_WAIT_LOCK;
            ctr_d   = '0;
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s2) begin
            state_d    = ST_RELEASE;
            ctr_d      = '0;
            soft_seq_d = 1'b0;
          end
        end
        ST_RELEASE: begin
          if (ctr_q == (soft_seq_q ? SOFT_LAST : HARD_LAST)) begin
            state_d = ST_RUN;
            ctr_d   = '0;
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (SYSRESETREQ) begin
            state_d             = ST_SOFT;
            ctr_d               = '0;
            cause_d[CAUSE_SOFT] = 1'b1;
          end
        end
        ST_SOFT: begin
          if (ctr_q == ASSERT_LAST) begin
            state_d    = ST_RELEASE;
            ctr_d      = '0;
            soft_seq_d = 1'b1;
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_ASSERT;
          ctr_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    READY  = (state_q == ST_RUN);
    rstn_d = RSTn;
    if (pll_loss || btn_rise) begin
      rstn_d = '0;
    end else begin
      case (state_q)
        ST_RELEASE: begin
          for (int i = 0; i < NUM_RST; i++) begin
            if (ctr_q >= (soft_seq_q ? soft_thr[i] : hard_thr[i])) rstn_d[i] = 1'b1;
          end
        end
        ST_RUN: begin
          if (SYSRESETREQ) rstn_d = RSTn & ~SOFT_MASK;
        end
        ST_SOFT: rstn_d = RSTn;
        default: rstn_d = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rst_seq.sv
// ============================================================================
// tb_rst_seq: directed table-driven bench for rst_seq defaults  (rev 1.0)
// ============================================================================
`default_nettype none

module tb_rst_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       btn;
  logic       sysresetreq;
  logic       cause_clr;
  logic [1:0] rstn;
  logic       ready;
  logic [3:0] rst_cause;

  always #5 clk = ~clk;

  rst_seq dut (
    .CLK         (clk),
    .RESET       (reset),
    .PLL_LOCKED  (pll_locked),
    .BTN         (btn),
    .SYSRESETREQ (sysresetreq),
    .CAUSE_CLR   (cause_clr),
    .RSTn        (rstn),
    .READY       (ready),
    .RST_CAUSE   (rst_cause)
  );

  typedef struct {
    int         edge_n;
    logic       lock;
    logic       sreq;
    logic       clr;
    logic [1:0] rstn;
    logic       ready;
    logic [3:0] cause;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp;
  int   n_bad;
  int   e;

  function automatic vec_t v(input int en, input logic l, input logic s, input logic c,
                             input logic [1:0] r, input logic rd, input logic [3:0] ca);
    vec_t t;
    t.edge_n = en; t.lock = l; t.sreq = s; t.clr = c;
    t.rstn = r; t.ready = rd; t.cause = ca;
    return t;
  endfunction

  // Advance to just after edge n (edge 0 is the first edge with RESET low).
  task automatic adv(input int n);
    while (e < n) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask

  task automatic chk(input string nm, input logic [1:0] r, input logic rd, input logic [3:0] ca);
    n_cmp++;
    if (rstn !== r) begin
      n_bad++;
      $display("FAIL %s_rstn edge %0d: got %b want %b", nm, e, rstn, r);
    end
    n_cmp++;
    if (ready !== rd) begin
      n_bad++;
      $display("FAIL %s_ready edge %0d: got %b want %b", nm, e, ready, rd);
    end
    n_cmp++;
    if (rst_cause !== ca) begin
      n_bad++;
      $display("FAIL %s_cause edge %0d: got %b want %b", nm, e, rst_cause, ca);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", 2'b00, 1'b0, 4'b0001);
    reset = 1'b0;
    e     = -1;
  endtask

  task automatic pulse_btn(input int hi, input int lo);
    btn = 1'b1;
    adv(e + hi);
    btn = 1'b0;
    adv(e + lo);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    n_cmp = 0; n_bad = 0; e = 0;
    reset = 1'b1; pll_locked = 1'b1; btn = 1'b0; sysresetreq = 1'b0; cause_clr = 1'b0;

    // Nominal release, soft reset, clear, lock drops (one with coincident clear).
    tbl.push_back(v(  0, 1, 0, 0, 2'b00, 0, 4'b0001));
    tbl.push_back(v( 15, 1, 0, 0, 2'b00, 0, 4'b0001));
    tbl.push_back(v( 16, 1, 0, 0, 2'b00, 0, 4'b0001));
    tbl.push_back(v( 17, 1, 0, 0, 2'b01, 0, 4'b0001));
    tbl.push_back(v( 26, 1, 0, 0, 2'b01, 0, 4'b0001));
    tbl.push_back(v( 27, 1, 0, 0, 2'b11, 1, 4'b0001));
    tbl.push_back(v( 40, 1, 1, 0, 2'b01, 0, 4'b1001));
    tbl.push_back(v( 41, 1, 0, 0, 2'b01, 0, 4'b1001));
    tbl.push_back(v( 56, 1, 0, 0, 2'b01, 0, 4'b1001));
    tbl.push_back(v( 57, 1, 0, 0, 2'b11, 1, 4'b1001));
    tbl.push_back(v( 60, 1, 0, 1, 2'b11, 1, 4'b0000));
    tbl.push_back(v( 61, 1, 0, 0, 2'b11, 1, 4'b0000));
    tbl.push_back(v( 70, 0, 0, 0, 2'b11, 1, 4'b0000));
    tbl.push_back(v( 71, 1, 0, 0, 2'b11, 1, 4'b0000));
    tbl.push_back(v( 72, 1, 0, 0, 2'b00, 0, 4'b0010));
    tbl.push_back(v( 89, 1, 0, 0, 2'b00, 0, 4'b0010));
    tbl.push_back(v( 90, 1, 0, 0, 2'b01, 0, 4'b0010));
    tbl.push_back(v( 99, 1, 0, 0, 2'b01, 0, 4'b0010));
    tbl.push_back(v(100, 1, 0, 0, 2'b11, 1, 4'b0010));
    tbl.push_back(v(105, 1, 1, 0, 2'b01, 0, 4'b1010));
    tbl.push_back(v(106, 1, 0, 0, 2'b01, 0, 4'b1010));
    tbl.push_back(v(121, 1, 0, 0, 2'b01, 0, 4'b1010));
    tbl.push_back(v(122, 1, 0, 0, 2'b11, 1, 4'b1010));
    tbl.push_back(v(130, 0, 0, 0, 2'b11, 1, 4'b1010));
    tbl.push_back(v(131, 1, 0, 0, 2'b11, 1, 4'b1010));
    tbl.push_back(v(132, 1, 0, 1, 2'b00, 0, 4'b0010));
    tbl.push_back(v(133, 1, 0, 0, 2'b00, 0, 4'b0010));
    tbl.push_back(v(150, 1, 0, 0, 2'b01, 0, 4'b0010));
    tbl.push_back(v(154, 1, 0, 0, 2'b01, 0, 4'b0010));

    do_reset();
    foreach (tbl[i]) begin
      vec_t t;
      t = tbl[i];
      adv(t.edge_n - 1);
      pll_locked  = t.lock;
      sysresetreq = t.sreq;
      cause_clr   = t.clr;
      adv(t.edge_n);
      chk("table", t.rstn, t.ready, t.cause);
    end

    // RESET asserted mid-RELEASE takes effect on the next edge.
    reset = 1'b1;
    adv(155);
    chk("reset_mid_release", 2'b00, 1'b0, 4'b0001);

    // Lock low out of reset; synchroniser output goes high at edge 40.
    pll_locked = 1'b0;
    do_reset();
    adv(30);
    chk("late_lock_wait", 2'b00, 1'b0, 4'b0001);
    adv(38);
    pll_locked = 1'b1;
    adv(40);
    chk("late_lock_e40", 2'b00, 1'b0, 4'b0001);
    adv(41);
    chk("late_lock_e41", 2'b00, 1'b0, 4'b0001);
    adv(42);
    chk("late_lock_e42", 2'b01, 1'b0, 4'b0001);
    adv(51);
    chk("late_lock_e51", 2'b01, 1'b0, 4'b0001);
    adv(52);
    chk("late_lock_e52", 2'b11, 1'b1, 4'b0001);

    // Glitches up to DEBOUNCE-1 cycles long must not fire an event.
    adv(60);
    pulse_btn(3, 10);
    pulse_btn(500, 10);
    pulse_btn(1023, 20);
    chk("btn_glitch", 2'b11, 1'b1, 4'b0001);

    // Held press: event DEBOUNCE+2 edges after it stabilises, ASSERT held
    // until DEBOUNCE after release, then a normal staggered release.
    b   = e + 1;
    btn = 1'b1;
    adv(b + 1025);
    chk("btn_pre_event", 2'b11, 1'b1, 4'b0001);
    adv(b + 1026);
    chk("btn_event", 2'b00, 1'b0, 4'b0101);
    adv(b + 1999);
    chk("btn_held", 2'b00, 1'b0, 4'b0101);
    btn = 1'b0;
    adv(b + 3042);
    chk("btn_rel_pre", 2'b00, 1'b0, 4'b0101);
    adv(b + 3043);
    chk("btn_rel_ch0", 2'b01, 1'b0, 4'b0101);
    adv(b + 3052);
    chk("btn_rel_pre1", 2'b01, 1'b0, 4'b0101);
    adv(b + 3053);
    chk("btn_rel_ch1", 2'b11, 1'b1, 4'b0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
